reg_wb_queue: RTL and testbench
===============================

# reg_wb_queue

Write-back stage directly upstream of the register file. Merges single-cycle ALU results with variable-latency load results into one write port, then drives the per-register write enables and shared data bus of the 16-bit register array. Loads are buffered in a small in-order queue. A queued load whose destination is overwritten by a newer ALU result is cancelled, which prevents write-after-write corruption.

## Interface
- DATA_W, 16, register data width
- NREG, 8, number of architectural registers
- ADDR_W, 3, register address width (log2 NREG)
- DEPTH, 4, load queue entries (power of two)

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- alu_we  in  1  ALU result valid this cycle; always accepted
- alu_waddr  in  ADDR_W  ALU destination register
- alu_wdata  in  DATA_W  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  queue can accept a load result
- ld_waddr  in  ADDR_W  load destination register
- ld_wdata  in  DATA_W  load data
- we  out  NREG  one-hot (or zero) register write enables, registered
- din  out  DATA_W  write data broadcast to all registers, registered
- pend  out  NREG  bit r set while a live queued load targets register r
- q_count  out  ADDR_W  occupied queue entries (0..DEPTH)

## Operation
- Reset values: we=0, din=0, pend=0, q_count=0, ld_ready=0 while rst is high. The queue is flushed and all entries are lost.
- ld_ready = !rst && (q_count < DEPTH). A push happens on ld_valid && ld_ready.
- A push stores {live=1, addr, data} at the tail.
- Per-cycle issue priority:
  - If alu_we: next we = onehot(alu_waddr), next din = alu_wdata.
  - Else if the queue is non-empty: pop the head. If the head is live: we = onehot(head.addr), din = head.data. If the head is dead: we = 0 and din holds its previous value.
  - Else: we = 0 and din holds its previous value.
- A dead head still consumes its pop cycle.
- Kill rule: when alu_we is high with address r, every live queue entry with addr r becomes dead at that edge.
  - A load pushed in the same cycle to r counts as older and is stored dead.
  - Entries to other addresses are unaffected.
- pend[r] = OR over live entries of (addr == r). It is derived from queue state only, so it reflects pushes and kills from the next cycle.
- Simultaneous push and pop are allowed when not full. A full queue refuses a push even if a pop occurs that cycle.
- Continuous alu_we starves the queue. ld_ready deasserts at full, and the decoder must tolerate this.
- q_count: +1 on push, −1 on pop, unchanged on both or neither. Head and tail pointers wrap modulo DEPTH.

## Timing
- ALU path: alu_we in cycle t → we/din asserted in cycle t+1 → register captures at the end of t+1.
- Load path with an empty queue and no ALU traffic: handshake in t → entry visible in t+1 → we/din in t+2.
- Load throughput: one load write per cycle when alu_we is low.
- Kill and pend updates take effect one cycle after the causing edge.
- rst asserted mid-operation: outputs reach reset values in the cycle after the sampled rst. A pending we already on the outputs during the rst cycle is not retracted.

## Structure
- Shared package/header holds DATA_W, ADDR_W, NREG, DEPTH defaults and the queue entry layout {live, addr[ADDR_W], data[DATA_W]}.
- One sub-module, wb_queue: a circular buffer with push, pop and a broadcast kill(addr) port. It outputs head entry, count and the live-address mask.
- The top level holds the priority mux, the one-hot decoder and the output registers.

## Test plan
- Reset: hold rst for 2 cycles with ld_valid=1 → we=0, din=0, pend=0, q_count=0, ld_ready=0, no push. After release, ld_ready=1.
- ALU only: alu_we=1, addr 5, data 0xBEEF in cycle t → we=8'b0010_0000, din=0xBEEF in t+1. we=0 in t+2.
- Load only: push addr 2, data 0x1234 at t → pend[2]=1 in t+1, we=8'b0000_0100 and din=0x1234 in t+2, pend=0 in t+2.
- Fill and back-pressure: push 4 loads while alu_we=1 continuously → q_count=4, ld_ready=0. Drop alu_we → four writes in consecutive cycles in push order, then ld_ready=1.
- Kill: queue loads to r3 (0xAAAA) and r4 (0xBBBB), then alu_we to r3 (0x5555) → r3 written 0x5555 once. Dead entry pop shows we=0. r4 gets 0xBBBB. pend[3] clears the cycle after the ALU write.
- Same-cycle kill: ld push to r6 and alu_we to r6 in the same cycle → only the ALU write to r6 appears, and the dead entry still occupies one pop cycle.

Source files
------------

// File: rtl/reg_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_queue_pkg
// Description : Shared widths, queue depth and load-queue entry layout for
//               the register write-back stage, plus a one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_queue_pkg;

  localparam int DATA_W = 16;               // register data width
  localparam int NREG   = 8;                // architectural registers
  localparam int ADDR_W = 3;                // log2(NREG)
  localparam int DEPTH  = 4;                // load queue entries, power of two
  localparam int PTR_W  = $clog2(DEPTH);    // circular-buffer pointer width

  // Queue entry: live clears when a newer ALU write targets the same register.
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage : reg_wb_queue_pkg
`default_nettype wire

// File: rtl/reg_wb_queue_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : wb_queue
// Description : In-order circular buffer of pending load write-backs with a
//               broadcast kill port that marks matching entries dead.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               push_i/entry_i   - enqueue an entry at the tail
//               pop_i            - dequeue the head entry
//               kill_i/addr_i    - mark live entries with that address dead
//               head_o           - current head entry
//               count_o          - occupied entries (0..DEPTH)
//               full_o, empty_o  - occupancy flags
//               live_mask_o      - bit r set while a live entry targets r
// Revision    : 1.0 - initial release
// ============================================================================
import reg_wb_queue_pkg::*;

module wb_queue (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  wb_entry_t         push_entry_i,
  input  logic              pop_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] kill_addr_i,
  output wb_entry_t         head_o,
  output logic [ADDR_W-1:0] count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [NREG-1:0]   live_mask_o
);

  localparam logic [ADDR_W-1:0] C_DEPTH_CNT = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_CNT_ONE   = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  C_PTR_ONE   = PTR_W'(1);

  wb_entry_t         entries_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [ADDR_W-1:0] count_q;

  logic              w_push;
  logic              w_pop;

  assign full_o  = (count_q == C_DEPTH_CNT);
  assign empty_o = (count_q == '0);
  // A full queue refuses a push even when a pop happens the same cycle.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign head_o  = entries_q[head_q];
  assign count_o = count_q;

  // Entry storage. Popped slots drop their live bit so the live mask only
  // reflects occupied entries. A push killed in the same cycle is older than
  // the ALU write and is stored dead.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (tail_q == PTR_W'(i))) begin
          entries_q[i].addr <= push_entry_i.addr;
          entries_q[i].data <= push_entry_i.data;
          entries_q[i].live <= push_entry_i.live &&
                               !(kill_i && (push_entry_i.addr == kill_addr_i));
        end else if (w_pop && (head_q == PTR_W'(i))) begin
          entries_q[i].live <= 1'b0;
        end else if (kill_i && (entries_q[i].addr == kill_addr_i)) begin
          entries_q[i].live <= 1'b0;
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) begin
        tail_q <= tail_q + C_PTR_ONE;
      end
      if (w_pop) begin
        head_q <= head_q + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        count_q <= count_q - C_CNT_ONE;
      end
    end
  end

  always_comb begin
    live_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].live) begin
        live_mask_o[entries_q[i].addr] = 1'b1;
      end
    end
  end

endmodule : wb_queue
`default_nettype wire

// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_queue
// Description : Write-back stage ahead of the register file. Merges
//               single-cycle ALU results with queued load results into one
//               registered write port (one-hot enables + shared data bus).
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               alu_we_i/waddr_i/wdata_i - ALU result, always accepted
//               ld_valid_i/ld_ready_o    - load result handshake
//               ld_waddr_i/ld_wdata_i    - load destination and data
//               we_o, din_o              - registered register-file write port
//               pend_o                   - live queued loads per register
//               q_count_o                - load queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
import reg_wb_queue_pkg::*;

module reg_wb_queue (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we_i,
  input  logic [ADDR_W-1:0] alu_waddr_i,
  input  logic [DATA_W-1:0] alu_wdata_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [ADDR_W-1:0] ld_waddr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic [NREG-1:0]   we_o,
  output logic [DATA_W-1:0] din_o,
  output logic [NREG-1:0]   pend_o,
  output logic [ADDR_W-1:0] q_count_o
);

  wb_entry_t         w_push_entry;
  wb_entry_t         w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  logic [NREG-1:0]   we_q;
  logic [NREG-1:0]   we_d;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] din_d;

  assign ld_ready_o   = !rst && !w_full;
  assign w_push       = ld_valid_i && ld_ready_o;
  // ALU results own the write port; the queue only drains on idle ALU cycles.
  assign w_pop        = !alu_we_i && !w_empty;

  assign w_push_entry = '{live: 1'b1, addr: ld_waddr_i, data: ld_wdata_i};

  wb_queue u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .kill_i       (alu_we_i),
    .kill_addr_i  (alu_waddr_i),
    .head_o       (w_head),
    .count_o      (q_count_o),
    .full_o       (w_full),
    .empty_o      (w_empty),
    .live_mask_o  (pend_o)
  );

  // Issue priority: ALU, then live queue head. A dead head still consumes
  // its pop cycle but produces no write; din holds when nothing is written.
  always_comb begin
    we_d  = '0;
    din_d = din_q;
    if (alu_we_i) begin
      we_d  = onehot(alu_waddr_i);
      din_d = alu_wdata_i;
    end else if (w_pop && w_head.live) begin
      we_d  = onehot(w_head.addr);
      din_d = w_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= '0;
      din_q <= '0;
    end else begin
      we_q  <= we_d;
      din_q <= din_d;
    end
  end

  assign we_o  = we_q;
  assign din_o = din_q;

endmodule : reg_wb_queue
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_queue
// Description : Directed self-checking bench for reg_wb_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [2:0]  alu_waddr;
  logic [15:0] alu_wdata;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_waddr;
  logic [15:0] ld_wdata;
  logic [7:0]  we;
  logic [15:0] din;
  logic [7:0]  pend;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_wb_queue dut (
    .clk         (clk),
    .rst         (rst),
    .alu_we_i    (alu_we),
    .alu_waddr_i (alu_waddr),
    .alu_wdata_i (alu_wdata),
    .ld_valid_i  (ld_valid),
    .ld_ready_o  (ld_ready),
    .ld_waddr_i  (ld_waddr),
    .ld_wdata_i  (ld_wdata),
    .we_o        (we),
    .din_o       (din),
    .pend_o      (pend),
    .q_count_o   (q_count)
  );

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we    = 1'b0;
    alu_waddr = '0;
    alu_wdata = '0;
    ld_valid  = 1'b0;
    ld_waddr  = '0;
    ld_wdata  = '0;
  endtask

  task automatic drive_alu(input logic [2:0] a, input logic [15:0] d);
    alu_we    = 1'b1;
    alu_waddr = a;
    alu_wdata = d;
  endtask

  task automatic drive_ld(input logic [2:0] a, input logic [15:0] d);
    ld_valid = 1'b1;
    ld_waddr = a;
    ld_wdata = d;
  endtask

  initial begin
    // ---------------- reset with a load offered ----------------
    idle_inputs();
    rst = 1'b1;
    drive_ld(3'd1, 16'hDEAD);
    #1;
    chk_val("rst_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    tick();
    chk_val("rst_we",      32'(we),       32'h00);
    chk_val("rst_din",     32'(din),      32'h0000);
    chk_val("rst_pend",    32'(pend),     32'h00);
    chk_val("rst_q_count", 32'(q_count),  32'd0);
    chk_val("rst_ready",   32'(ld_ready), 32'd0);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_val("rel_ready",   32'(ld_ready), 32'd1);

    // ---------------- ALU only ----------------
    drive_alu(3'd5, 16'hBEEF);
    tick();
    idle_inputs();
    chk_val("alu_we",      32'(we),  32'h20);
    chk_val("alu_din",     32'(din), 32'hBEEF);
    tick();
    chk_val("alu_we_off",  32'(we),  32'h00);
    chk_val("alu_din_hold",32'(din), 32'hBEEF);

    // ---------------- load only ----------------
    drive_ld(3'd2, 16'h1234);
    tick();
    idle_inputs();
    chk_val("ld_pend",     32'(pend),    32'h04);
    chk_val("ld_cnt1",     32'(q_count), 32'd1);
    chk_val("ld_we_t1",    32'(we),      32'h00);
    tick();
    chk_val("ld_we",       32'(we),      32'h04);
    chk_val("ld_din",      32'(din),     32'h1234);
    chk_val("ld_pend_clr", 32'(pend),    32'h00);
    chk_val("ld_cnt0",     32'(q_count), 32'd0);

    // ---------------- fill under ALU traffic, back-pressure ----------------
    drive_alu(3'd0, 16'h0001);
    drive_ld(3'd1, 16'h1111); tick();
    drive_ld(3'd2, 16'h2222); tick();
    drive_ld(3'd3, 16'h3333); tick();
    drive_ld(3'd7, 16'h7777); tick();
    chk_val("fill_cnt",    32'(q_count),  32'd4);
    chk_val("fill_ready",  32'(ld_ready), 32'd0);
    chk_val("fill_we",     32'(we),       32'h01);
    drive_ld(3'd5, 16'h5555); tick();
    chk_val("full_refuse", 32'(q_count),  32'd4);
    chk_val("full_pend",   32'(pend),     32'h8E);
    idle_inputs();
    tick();
    chk_val("drain0_we",   32'(we),  32'h02);
    chk_val("drain0_din",  32'(din), 32'h1111);
    tick();
    chk_val("drain1_we",   32'(we),  32'h04);
    chk_val("drain1_din",  32'(din), 32'h2222);
    tick();
    chk_val("drain2_we",   32'(we),  32'h08);
    chk_val("drain2_din",  32'(din), 32'h3333);
    tick();
    chk_val("drain3_we",   32'(we),  32'h80);
    chk_val("drain3_din",  32'(din), 32'h7777);
    chk_val("drain_cnt",   32'(q_count),  32'd0);
    chk_val("drain_ready", 32'(ld_ready), 32'd1);

    // ---------------- kill of an older queued load ----------------
    drive_alu(3'd0, 16'h0002);
    drive_ld(3'd3, 16'hAAAA); tick();
    drive_ld(3'd4, 16'hBBBB); tick();
    chk_val("kill_pend0",  32'(pend), 32'h18);
    idle_inputs();
    drive_alu(3'd3, 16'h5555);
    tick();
    idle_inputs();
    chk_val("kill_we",     32'(we),   32'h08);
    chk_val("kill_din",    32'(din),  32'h5555);
    chk_val("kill_pend1",  32'(pend), 32'h10);
    tick();
    chk_val("dead_we",     32'(we),      32'h00);
    chk_val("dead_din",    32'(din),     32'h5555);
    chk_val("dead_cnt",    32'(q_count), 32'd1);
    tick();
    chk_val("r4_we",       32'(we),      32'h10);
    chk_val("r4_din",      32'(din),     32'hBBBB);
    chk_val("r4_cnt",      32'(q_count), 32'd0);
    tick();
    chk_val("kill_idle",   32'(we),      32'h00);

    // ---------------- same-cycle push and kill ----------------
    drive_alu(3'd6, 16'h0606);
    drive_ld(3'd6, 16'h6666);
    tick();
    idle_inputs();
    chk_val("same_we",     32'(we),      32'h40);
    chk_val("same_din",    32'(din),     32'h0606);
    chk_val("same_pend",   32'(pend),    32'h00);
    chk_val("same_cnt",    32'(q_count), 32'd1);
    tick();
    chk_val("same_dead_we",  32'(we),      32'h00);
    chk_val("same_dead_din", 32'(din),     32'h0606);
    chk_val("same_dead_cnt", 32'(q_count), 32'd0);

    // ---------------- reset mid-operation flushes the queue ----------------
    drive_alu(3'd1, 16'h0011);
    drive_ld(3'd2, 16'h0022); tick();
    drive_ld(3'd5, 16'h0055); tick();
    chk_val("pre_rst_cnt", 32'(q_count), 32'd2);
    idle_inputs();
    rst = 1'b1;
    tick();
    chk_val("mid_rst_cnt",  32'(q_count),  32'd0);
    chk_val("mid_rst_we",   32'(we),       32'h00);
    chk_val("mid_rst_din",  32'(din),      32'h0000);
    chk_val("mid_rst_pend", 32'(pend),     32'h00);
    chk_val("mid_rst_rdy",  32'(ld_ready), 32'd0);
    rst = 1'b0;
    tick();
    chk_val("post_rst_we",  32'(we),       32'h00);
    chk_val("post_rst_rdy", 32'(ld_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_wb_queue
`default_nettype wire
